tv80_mem_arbiter: RTL and testbench

- Shares one synchronous-read program/data RAM between the TV80 CPU bus and a host loader/inspection port used by the test harness.
- The host uses this port to preload opcodes and to read back memory after a run.
- CPU has priority. The host is granted when the CPU bus is idle, or once the host has waited STARVE_LIMIT cycles.
- Inserts CPU wait states (wait_n) while RAM latency or a host access is outstanding. Sits between the tv80 core and the tb memory array.

---
 rtl/tv80_mem_arbiter_if.sv | 42 ++++
 rtl/tv80_mem_arbiter.sv | 134 +++++++++++++
 tb/tb_tv80_mem_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tv80_mem_arbiter_if.sv
// tv80_mem_arbiter_if: CPU, host and RAM bus signals around the TV80 memory arbiter
interface tv80_mem_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 8
);
    logic          cpu_mreq_n;
    logic          cpu_rd_n;
    logic          cpu_wr_n;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_dout;
    logic [DW-1:0] cpu_di;
    logic          cpu_wait_n;
    logic          host_req;
    logic          host_we;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic          host_ack;
    logic [DW-1:0] host_rdata;
    logic          mem_cs;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  cpu_mreq_n, cpu_rd_n, cpu_wr_n, cpu_addr, cpu_dout,
        output cpu_di, cpu_wait_n,
        input  host_req, host_we, host_addr, host_wdata,
        output host_ack, host_rdata,
        output mem_cs, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output cpu_mreq_n, cpu_rd_n, cpu_wr_n, cpu_addr, cpu_dout,
        input  cpu_di, cpu_wait_n,
        output host_req, host_we, host_addr, host_wdata,
        input  host_ack, host_rdata,
        input  mem_cs, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/tv80_mem_arbiter.sv
// tv80_mem_arbiter: shares one synchronous-read RAM between the TV80 bus and a host loader port
module tv80_mem_arbiter #(
    parameter int AW           = 16,
    parameter int DW           = 8,
    parameter int MEM_LAT      = 1,
    parameter int STARVE_LIMIT = 8
) (
    input logic               clk,
    input logic               reset_n,
    tv80_mem_arbiter_if.slave bus
);
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] CPU_RD  = 3'd1;
    localparam logic [2:0] CPU_WR  = 3'd2;
    localparam logic [2:0] HOST_RD = 3'd3;
    localparam logic [2:0] HOST_WR = 3'd4;
    localparam logic [1:0] LAT     = 2'(MEM_LAT);
    localparam logic [7:0] LIMIT   = 8'(STARVE_LIMIT);

    logic [2:0]    state;
    logic [1:0]    cnt;
    logic [7:0]    starve;
    logic          cpu_served;
    logic          cpu_abort;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] cpu_di_q;
    logic          host_ack_q;
    logic [DW-1:0] host_rdata_q;
    logic          cpu_valid;
    logic          host_pend;
    logic          host_busy;
    logic          host_win;
    logic          cpu_win;
    logic          lat_done;
    logic          we_nx;
    logic [AW-1:0] addr_nx;
    logic [DW-1:0] wdata_nx;

    // Arbitration is decided in IDLE and the RAM command goes out in that same cycle;
    // the host request is ignored during its own ack cycle so it is not re-granted
    always_comb begin
        cpu_valid = !bus.cpu_mreq_n && (!bus.cpu_rd_n || !bus.cpu_wr_n) && !cpu_served;
        host_pend = bus.host_req && !host_ack_q;
        host_busy = state == HOST_RD || state == HOST_WR;
        host_win  = reset_n && state == IDLE && host_pend && (!cpu_valid || starve >= LIMIT);
        cpu_win   = reset_n && state == IDLE && cpu_valid && !host_win;
        lat_done  = cnt == LAT;
        we_nx     = host_win ? bus.host_we : cpu_win ? !bus.cpu_wr_n : we_q;
        addr_nx   = host_win ? bus.host_addr : cpu_win ? bus.cpu_addr : addr_q;
        wdata_nx  = host_win ? bus.host_wdata : cpu_win ? bus.cpu_dout : wdata_q;
    end

    assign bus.mem_cs     = host_win || cpu_win;
    assign bus.mem_we     = we_nx;
    assign bus.mem_addr   = addr_nx;
    assign bus.mem_wdata  = wdata_nx;
    assign bus.cpu_wait_n = !(cpu_valid && reset_n);
    assign bus.cpu_di     = cpu_di_q;
    assign bus.host_ack   = host_ack_q;
    assign bus.host_rdata = host_rdata_q;

    // Access sequencing, starvation counting and one-op-per-machine-cycle bookkeeping
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            cnt          <= '0;
            starve       <= '0;
            cpu_served   <= 1'b0;
            cpu_abort    <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            cpu_di_q     <= '0;
            host_ack_q   <= 1'b0;
            host_rdata_q <= '0;
        end else begin
            host_ack_q <= 1'b0;
            we_q       <= we_nx;
            addr_q     <= addr_nx;
            wdata_q    <= wdata_nx;
            starve     <= host_win ? 8'd0 :
                          (host_pend && !host_busy && starve != 8'hff) ? starve + 8'd1 : starve;
            if (bus.cpu_mreq_n)
                cpu_served <= 1'b0;
            case (state)
                IDLE: begin
                    cnt       <= 2'd1;
                    cpu_abort <= 1'b0;
                    if (host_win)
                        state <= bus.host_we ? HOST_WR : HOST_RD;
                    else if (cpu_win)
                        state <= !bus.cpu_wr_n ? CPU_WR : CPU_RD;
                end
                CPU_RD: begin
                    if (bus.cpu_mreq_n)
                        cpu_abort <= 1'b1;
                    if (lat_done) begin
                        state <= IDLE;
                        if (!bus.cpu_mreq_n && !cpu_abort) begin
                            cpu_di_q   <= bus.mem_rdata;
                            cpu_served <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 2'd1;
                    end
                end
                CPU_WR: begin
                    state <= IDLE;
                    if (!bus.cpu_mreq_n && !cpu_abort)
                        cpu_served <= 1'b1;
                end
                HOST_RD: begin
                    if (lat_done) begin
                        state        <= IDLE;
                        host_rdata_q <= bus.mem_rdata;
                        host_ack_q   <= 1'b1;
                    end else begin
                        cnt <= cnt + 2'd1;
                    end
                end
                HOST_WR: begin
                    state      <= IDLE;
                    host_ack_q <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    a_cs_pulse: assert property (@(posedge clk) disable iff (!reset_n) bus.mem_cs |=> !bus.mem_cs);
    a_ack_pulse: assert property (@(posedge clk) disable iff (!reset_n) bus.host_ack |=> !bus.host_ack);
endmodule

// File: tb/tb_tv80_mem_arbiter.sv
// tb_tv80_mem_arbiter: randomized scoreboard bench for the TV80 memory arbiter
module tb_tv80_mem_arbiter;
    localparam int AW  = 16;
    localparam int DW  = 8;
    localparam int LAT = 1;
    localparam int SL  = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    tv80_mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    tv80_mem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(LAT), .STARVE_LIMIT(SL)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    // RAM environment: synchronous write, read data LAT cycles after mem_cs, filler otherwise
    logic [7:0] ram [0:65535] = '{default: 8'h00};
    logic [7:0] rpipe [1:LAT];
    always @(posedge clk) begin
        if (bus.mem_cs && bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
        rpipe[1] <= (bus.mem_cs && !bus.mem_we) ? ram[bus.mem_addr] : 8'hEE;
        for (int i = 2; i <= LAT; i++) rpipe[i] <= rpipe[i-1];
    end
    assign bus.mem_rdata = rpipe[LAT];

    // Reference: the memory contents as seen in issue order
    logic [7:0] model [0:65535] = '{default: 8'h00};
    logic [7:0] cpu_q [$];
    logic [8:0] host_q [$];

    int checks = 0, failures = 0;
    int cyc = 0, cs_cnt = 0, ack_cnt = 0, cpu_done_cyc = 0, host_ack_cyc = 0;
    int starve_cpu_grants = 0, starve_snap = -1;
    bit was_waiting = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Monitor: counts RAM grants and pops the scoreboard on CPU read completion and host ack
    always @(negedge clk) begin
        if (bus.mem_cs) begin
            cs_cnt++;
            if (!bus.mem_we && bus.mem_addr == 16'h0040) starve_cpu_grants++;
            if (bus.mem_addr == 16'h0050) starve_snap = starve_cpu_grants;
        end
        if (bus.cpu_mreq_n) was_waiting = 0;
        else if (!bus.cpu_wait_n) was_waiting = 1;
        else if (was_waiting) begin
            was_waiting = 0;
            cpu_done_cyc = cyc;
            if (!bus.cpu_rd_n && bus.cpu_wr_n) begin
                if (cpu_q.size() == 0) chk("cpu_unexpected_read", 1, 0);
                else chk("cpu_di", bus.cpu_di, cpu_q.pop_front());
            end
        end
        if (bus.host_ack) begin
            ack_cnt++;
            host_ack_cyc = cyc;
            if (host_q.size() == 0) chk("host_unexpected_ack", 1, 0);
            else begin
                logic [8:0] e;
                e = host_q.pop_front();
                if (!e[8]) chk("host_rdata", bus.host_rdata, e[7:0]);
            end
        end
    end

    // mode 0 = read, 1 = write, 2 = both strobes low (write)
    task automatic cpu_op(input int mode, input logic [15:0] a, input logic [7:0] d, output int waits);
        bit done;
        waits = 0;
        done = 0;
        @(posedge clk); #1;
        bus.cpu_addr = a;
        bus.cpu_dout = d;
        bus.cpu_mreq_n = 1'b0;
        bus.cpu_rd_n = (mode == 1);
        bus.cpu_wr_n = (mode == 0);
        if (mode == 0) cpu_q.push_back(model[a]);
        else model[a] = d;
        while (!done) begin
            @(negedge clk);
            if (bus.cpu_wait_n) done = 1;
            else begin
                waits++;
                if (waits >= 60) begin
                    chk("cpu_wait_timeout", waits, 0);
                    done = 1;
                end
            end
        end
        @(posedge clk); #1;
        bus.cpu_mreq_n = 1'b1;
        bus.cpu_rd_n = 1'b1;
        bus.cpu_wr_n = 1'b1;
    endtask

    task automatic host_op(input logic we, input logic [15:0] a, input logic [7:0] d);
        int n;
        n = 0;
        @(posedge clk); #1;
        bus.host_req = 1'b1;
        bus.host_we = we;
        bus.host_addr = a;
        bus.host_wdata = d;
        host_q.push_back({we, we ? d : model[a]});
        if (we) model[a] = d;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.host_ack && n < 60);
        if (!bus.host_ack) chk("host_ack_timeout", n, 0);
        @(posedge clk); #1;
        bus.host_req = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_wait_n"}, bus.cpu_wait_n, 1);
        chk({tag, "_cpu_di"}, bus.cpu_di, 0);
        chk({tag, "_host_ack"}, bus.host_ack, 0);
        chk({tag, "_host_rdata"}, bus.host_rdata, 0);
        chk({tag, "_mem_cs"}, bus.mem_cs, 0);
        chk({tag, "_mem_we"}, bus.mem_we, 0);
        chk({tag, "_mem_addr"}, bus.mem_addr, 0);
        chk({tag, "_mem_wdata"}, bus.mem_wdata, 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int w, w2, n, cs0, acks0, lows, highs;
    bit back_low, stop;
    logic [15:0] a;
    logic [7:0] d;

    initial begin
        bus.cpu_mreq_n = 1'b1;
        bus.cpu_rd_n = 1'b1;
        bus.cpu_wr_n = 1'b1;
        bus.cpu_addr = '0;
        bus.cpu_dout = '0;
        bus.host_req = 1'b0;
        bus.host_we = 1'b0;
        bus.host_addr = '0;
        bus.host_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1;
        reset_n = 1'b1;

        // CPU read only
        host_op(1, 16'h0000, 8'hFD);
        cs0 = cs_cnt;
        cpu_op(0, 16'h0000, 8'h00, w);
        chk("rd_only_waits", w, LAT + 1);
        chk("rd_only_cs", cs_cnt - cs0, 1);

        // Host preload then CPU fetch
        acks0 = ack_cnt;
        host_op(1, 16'h0000, 8'hFD);
        host_op(1, 16'h0001, 8'h07);
        host_op(1, 16'h0002, 8'hFF);
        chk("preload_acks", ack_cnt - acks0, 3);
        for (int i = 0; i < 3; i++) begin
            cpu_op(0, 16'(i), 8'h00, w);
            chk("fetch_waits", w, LAT + 1);
        end

        // Simultaneous requests: CPU first, host after
        host_op(1, 16'h0010, 8'h3C);
        cpu_op(1, 16'h0020, 8'hC3, w);
        fork
            host_op(0, 16'h0010, 8'h00);
            cpu_op(0, 16'h0020, 8'h00, w2);
        join
        chk("simul_cpu_waits", w2, LAT + 1);
        chk("simul_cpu_first", host_ack_cyc > cpu_done_cyc, 1);

        // Starvation: CPU aborts and re-requests every arbitration cycle; two rounds show the counter clears
        for (int r = 0; r < 2; r++) begin
            starve_cpu_grants = 0;
            starve_snap = -1;
            stop = 0;
            fork
                begin
                    host_op(0, 16'h0050, 8'h00);
                    stop = 1;
                end
                begin
                    @(posedge clk); #1;
                    bus.cpu_addr = 16'h0040;
                    bus.cpu_rd_n = 1'b0;
                    bus.cpu_wr_n = 1'b1;
                    for (int i = 0; i < 60 && !stop; i++) begin
                        bus.cpu_mreq_n = i[0];
                        @(posedge clk); #1;
                    end
                    bus.cpu_mreq_n = 1'b1;
                    bus.cpu_rd_n = 1'b1;
                end
            join
            chk("starve_cpu_grants", starve_snap, (SL + LAT) / (LAT + 1));
        end

        // One RAM op per machine cycle
        repeat (2) @(posedge clk);
        cs0 = cs_cnt;
        lows = 0;
        highs = 0;
        back_low = 0;
        @(posedge clk); #1;
        bus.cpu_addr = 16'h0001;
        bus.cpu_mreq_n = 1'b0;
        bus.cpu_rd_n = 1'b0;
        cpu_q.push_back(model[16'h0001]);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.cpu_wait_n) highs++;
            else begin
                if (highs > 0) back_low = 1;
                lows++;
            end
        end
        @(posedge clk); #1;
        bus.cpu_mreq_n = 1'b1;
        bus.cpu_rd_n = 1'b1;
        chk("one_op_cs", cs_cnt - cs0, 1);
        chk("one_op_wait_lows", lows, LAT + 1);
        chk("one_op_wait_stays_high", back_low, 0);

        // Both strobes low is a write
        cpu_op(2, 16'h0030, 8'h5A, w);
        cpu_op(0, 16'h0030, 8'h00, w);
        chk("both_low_then_read_waits", w, LAT + 1);

        // Reset in the middle of a host read
        @(posedge clk); #1;
        bus.host_req = 1'b1;
        bus.host_we = 1'b0;
        bus.host_addr = 16'h0002;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.mem_cs && n < 20);
        chk("midrst_grant_seen", bus.mem_cs, 1);
        @(posedge clk); #1;
        acks0 = ack_cnt;
        cs0 = cs_cnt;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        bus.host_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (3) @(posedge clk);
        chk("midrst_no_ack", ack_cnt - acks0, 0);
        chk("midrst_no_cs", cs_cnt - cs0, 0);
        cpu_op(0, 16'h0002, 8'h00, w);
        chk("midrst_idle_after", w, LAT + 1);

        // Random sequential traffic, hitting a small address pool for read-after-write reuse
        for (int i = 0; i < 80; i++) begin
            a = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 15));
            d = 8'($urandom);
            case ($urandom_range(0, 4))
                0: host_op(0, a, 8'h00);
                1: host_op(1, a, d);
                2: cpu_op(0, a, 8'h00, w);
                3: cpu_op(1, a, d, w);
                default: cpu_op(2, a, d, w);
            endcase
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        // Random concurrent traffic on disjoint address regions
        for (int i = 0; i < 30; i++) begin
            fork
                host_op(1'($urandom), 16'h8000 | 16'($urandom_range(0, 15)), 8'($urandom));
                cpu_op($urandom_range(0, 2), 16'($urandom_range(0, 15)), 8'($urandom), w2);
            join
        end

        repeat (4) @(posedge clk);
        chk("cpu_q_drained", cpu_q.size(), 0);
        chk("host_q_drained", host_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
